// File: rtl/latch_write_arbiter_if.sv
// Requester-side bundle for the shared-latch write arbiter.
// Master drives requests and data; slave (the arbiter) returns grants and the latch controls.
interface latch_write_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] d_in;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  latch_en;
  logic [WIDTH-1:0]      latch_d;

  modport master (
    output req, lock, d_in,
    input  gnt, ack, latch_en, latch_d
  );

  modport slave (
    input  req, lock, d_in,
    output gnt, ack, latch_en, latch_d
  );
endinterface

// File: rtl/latch_write_arbiter.sv
// Round-robin owner of a single shared level-sensitive latch, with capped locked bursts.
// Every grant ends with one idle cycle so the next arbitration sees a settled pointer.
module latch_write_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  latch_write_arbiter_if.slave  bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_HOLD);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  own_q, own_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              latch_en_q, latch_en_d;
  logic [WIDTH-1:0]  latch_d_q, latch_d_d;

  logic [PTR_W-1:0]  pick;
  logic              own_lock;
  logic              own_req;
  logic [WIDTH-1:0]  own_data;
  logic [WIDTH-1:0]  pick_data;

  function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (idx == PTR_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] sel_data(input logic [NREQ*WIDTH-1:0] din,
                                                input logic [PTR_W-1:0]      idx);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (idx == PTR_W'(i)) v = din[i*WIDTH +: WIDTH];
    end
    return v;
  endfunction

  function automatic logic sel_bit(input logic [NREQ-1:0]  vec,
                                   input logic [PTR_W-1:0] idx);
    logic v;
    v = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (idx == PTR_W'(i)) v = vec[i];
    end
    return v;
  endfunction

  // Scan from the largest offset down so the request closest to ptr wins.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0]  r,
                                               input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] w;
    int               idx;
    w = p;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % NREQ;
      if (r[idx]) w = PTR_W'(idx);
    end
    return w;
  endfunction

  always_comb begin
    pick      = rr_pick(bus.req, ptr_q);
    pick_data = sel_data(bus.d_in, pick);
    own_lock  = sel_bit(bus.lock, own_q);
    own_req   = sel_bit(bus.req, own_q);
    own_data  = sel_data(bus.d_in, own_q);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    own_d      = own_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    latch_en_d = 1'b0;
    latch_d_d  = latch_d_q;

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        cnt_d = '0;
        if (|bus.req) begin
          state_d    = GRANT;
          own_d      = pick;
          gnt_d      = onehot(pick);
          ack_d      = onehot(pick);
          latch_en_d = 1'b1;
          latch_d_d  = pick_data;
          cnt_d      = CNT_W'(1);
        end
      end

      GRANT, HOLD: begin
        if (own_lock && (cnt_q < MAX_CNT)) begin
          // Owner keeps the latch; a dropped req just idles inside the burst.
          state_d = HOLD;
          if (own_req) begin
            ack_d      = onehot(own_q);
            latch_en_d = 1'b1;
            latch_d_d  = own_data;
            cnt_d      = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = (own_q == LAST_IDX) ? '0 : own_q + PTR_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      own_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      latch_en_q <= 1'b0;
      latch_d_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      own_q      <= own_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      latch_en_q <= latch_en_d;
      latch_d_q  <= latch_d_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.latch_en = latch_en_q;
  assign bus.latch_d  = latch_d_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed bench for latch_write_arbiter: a MAX_HOLD=4 instance plus a MAX_HOLD=1 instance
// fed the same requests, checked with immediate assertions after each clock edge.
module tb_latch_write_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic [7:0] dv [4];

  int total = 0;
  int bad   = 0;

  latch_write_arbiter_if #(.WIDTH(8), .NREQ(4)) bus_a ();
  latch_write_arbiter_if #(.WIDTH(8), .NREQ(4)) bus_b ();

  assign bus_a.req  = req;
  assign bus_a.lock = lock;
  assign bus_a.d_in = {dv[3], dv[2], dv[1], dv[0]};
  assign bus_b.req  = req;
  assign bus_b.lock = lock;
  assign bus_b.d_in = {dv[3], dv[2], dv[1], dv[0]};

  latch_write_arbiter #(.WIDTH(8), .NREQ(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  latch_write_arbiter #(.WIDTH(8), .NREQ(4), .MAX_HOLD(1)) dut_m1 (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_a(input string tag, input logic [3:0] g, input logic [3:0] a,
                          input logic e, input logic [7:0] d);
    chk({tag, ".gnt"},      32'(bus_a.gnt),      32'(g));
    chk({tag, ".ack"},      32'(bus_a.ack),      32'(a));
    chk({tag, ".latch_en"}, 32'(bus_a.latch_en), 32'(e));
    chk({tag, ".latch_d"},  32'(bus_a.latch_d),  32'(d));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] oh;
    rst_n = 1'b0;
    req   = 4'b1111;
    lock  = 4'b0000;
    dv[0] = 8'h10; dv[1] = 8'h20; dv[2] = 8'h30; dv[3] = 8'h40;

    // Reset held with all requests pending.
    step(); step();
    expect_a("rst_hold", 4'b0000, 4'b0000, 1'b0, 8'h00);
    rst_n = 1'b1;
    step();
    expect_a("rst_first", 4'b0001, 4'b0001, 1'b1, 8'h10);
    req = 4'b0000;
    step();
    expect_a("rst_release", 4'b0000, 4'b0000, 1'b0, 8'h10);

    // Single unlocked write: ptr is 1, requester 0 found by wrap.
    req = 4'b0001; dv[0] = 8'hA5;
    step();
    expect_a("single_w", 4'b0001, 4'b0001, 1'b1, 8'hA5);
    req = 4'b0000;
    step();
    expect_a("single_rel", 4'b0000, 4'b0000, 1'b0, 8'hA5);

    // Asynchronous reset from IDLE restores ptr=0 and clears latch_d.
    rst_n = 1'b0;
    #1;
    expect_a("async_rst", 4'b0000, 4'b0000, 1'b0, 8'h00);
    step();
    rst_n = 1'b1;

    // Round robin with everyone requesting, no lock.
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33; dv[3] = 8'h44;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      step();
      expect_a($sformatf("rr_w%0d", k), oh, oh, 1'b1, dv[k % 4]);
      step();
      expect_a($sformatf("rr_b%0d", k), 4'b0000, 4'b0000, 1'b0, dv[k % 4]);
    end
    req = 4'b0000;

    // Locked burst capped at MAX_HOLD=4; ptr is 1 so requester 2 wins first.
    req = 4'b0100; lock = 4'b0100; dv[2] = 8'h01;
    step();
    expect_a("burst_w1", 4'b0100, 4'b0100, 1'b1, 8'h01);
    chk("m1_w1.gnt", 32'(bus_b.gnt), 32'h4);
    req = 4'b0110; dv[2] = 8'h02;
    step();
    expect_a("burst_w2", 4'b0100, 4'b0100, 1'b1, 8'h02);
    chk("m1_rel.gnt", 32'(bus_b.gnt), 32'h0);
    chk("m1_rel.latch_en", 32'(bus_b.latch_en), 32'h0);
    dv[2] = 8'h03;
    step();
    expect_a("burst_w3", 4'b0100, 4'b0100, 1'b1, 8'h03);
    dv[2] = 8'h04;
    step();
    expect_a("burst_w4", 4'b0100, 4'b0100, 1'b1, 8'h04);
    dv[2] = 8'h05;
    step();
    expect_a("burst_cap", 4'b0000, 4'b0000, 1'b0, 8'h04);
    dv[1] = 8'h77;
    step();
    expect_a("burst_next", 4'b0010, 4'b0010, 1'b1, 8'h77);

    // Owner 1 unlocked; requester 3 lock/req ignored until next arbitration.
    req = 4'b1010; lock = 4'b1000; dv[3] = 8'hC3;
    step();
    expect_a("nonown_ign", 4'b0000, 4'b0000, 1'b0, 8'h77);
    step();
    expect_a("own3_w1", 4'b1000, 4'b1000, 1'b1, 8'hC3);
    dv[3] = 8'hC4;
    step();
    expect_a("own3_w2", 4'b1000, 4'b1000, 1'b1, 8'hC4);
    lock = 4'b0000;
    step();
    expect_a("own3_rel", 4'b0000, 4'b0000, 1'b0, 8'hC4);
    dv[1] = 8'h78;
    step();
    expect_a("wrap_ptr0", 4'b0010, 4'b0010, 1'b1, 8'h78);
    req = 4'b0000;
    step();
    expect_a("wrap_rel", 4'b0000, 4'b0000, 1'b0, 8'h78);

    // Locked owner 2 drops req for one cycle; count must not advance.
    req = 4'b0100; lock = 4'b0100; dv[2] = 8'h51;
    step();
    expect_a("gap_w1", 4'b0100, 4'b0100, 1'b1, 8'h51);
    req = 4'b0000; dv[2] = 8'h52;
    step();
    expect_a("gap_idle", 4'b0100, 4'b0000, 1'b0, 8'h51);
    req = 4'b0100; dv[2] = 8'h53;
    step();
    expect_a("gap_w2", 4'b0100, 4'b0100, 1'b1, 8'h53);
    dv[2] = 8'h54;
    step();
    expect_a("gap_w3", 4'b0100, 4'b0100, 1'b1, 8'h54);
    dv[2] = 8'h55;
    step();
    expect_a("gap_w4", 4'b0100, 4'b0100, 1'b1, 8'h55);
    step();
    expect_a("gap_cap", 4'b0000, 4'b0000, 1'b0, 8'h55);

    // Lock without req in IDLE starts nothing.
    req = 4'b0000; lock = 4'b1111;
    step();
    expect_a("lock_noreq", 4'b0000, 4'b0000, 1'b0, 8'h55);

    // Reset in the middle of a burst aborts it immediately.
    req = 4'b0001; lock = 4'b0001; dv[0] = 8'h61;
    step();
    expect_a("abort_w1", 4'b0001, 4'b0001, 1'b1, 8'h61);
    dv[0] = 8'h62;
    step();
    expect_a("abort_w2", 4'b0001, 4'b0001, 1'b1, 8'h62);
    dv[0] = 8'h63;
    #1;
    rst_n = 1'b0;
    #1;
    expect_a("abort_rst", 4'b0000, 4'b0000, 1'b0, 8'h00);
    step();
    expect_a("abort_hold", 4'b0000, 4'b0000, 1'b0, 8'h00);
    rst_n = 1'b1;
    req = 4'b0000; lock = 4'b0000;
    step();
    expect_a("post_rst", 4'b0000, 4'b0000, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
